// File: rtl/subleq_loader_mem_pkg.sv
// Shared types and sizing helpers for the subleq program loader / memory block.
package subleq_loader_mem_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    function automatic int depth_of(input int addr_bits);
        return 32'sd1 << addr_bits;
    endfunction

    // The top memory word is reserved as the halt mailbox by default.
    function automatic int halt_addr_of(input int addr_bits);
        return (32'sd1 << addr_bits) - 32'sd1;
    endfunction

endpackage

// File: rtl/subleq_loader_mem_if.sv
// Load-stream and core-control signals between the loader/memory block and its users.
interface subleq_loader_mem_if #(
    parameter int BITS = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] in_data;
    logic            in_last;
    logic            cpu_reset;
    logic            cpu_write;
    logic [BITS-1:0] cpu_address;
    logic            halted;
    logic [BITS-1:0] halt_value;
    logic            load_err;

    modport master (
        output in_valid, in_data, in_last, cpu_write, cpu_address,
        input  in_ready, cpu_reset, halted, halt_value, load_err
    );

    modport slave (
        input  in_valid, in_data, in_last, cpu_write, cpu_address,
        output in_ready, cpu_reset, halted, halt_value, load_err
    );
endinterface

// File: rtl/subleq_loader_mem_ram.sv
// Single-port word RAM: asynchronous read, synchronous write, contents not reset.
module subleq_loader_mem_ram
    import subleq_loader_mem_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [BITS-1:0]      wdata,
    output logic [BITS-1:0]      rdata
);

    logic [BITS-1:0] mem_r [depth_of(ADDR_BITS)];

    // Synchronous write port.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/subleq_loader_mem.sv
// Program loader and shared-bus memory for the subleq core: loads a word stream,
// runs the core against the RAM, and parks it when it writes the halt mailbox.
module subleq_loader_mem
    import subleq_loader_mem_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int ADDR_BITS = 5,
    parameter int HALT_ADDR = halt_addr_of(ADDR_BITS)
) (
    input  logic                 clock,
    input  logic                 reset,
    subleq_loader_mem_if.slave   bus,
    inout  wire  [BITS-1:0]      cpu_data
);

    localparam logic [ADDR_BITS-1:0] HALT_IDX = ADDR_BITS'(HALT_ADDR);
    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(depth_of(ADDR_BITS) - 1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

    state_e               state_r;
    state_e               state_next_s;
    logic [ADDR_BITS-1:0] ptr_r;
    logic [ADDR_BITS-1:0] cpu_idx_s;
    logic [ADDR_BITS-1:0] ram_addr_s;
    logic [BITS-1:0]      ram_wdata_s;
    logic [BITS-1:0]      ram_rdata_s;
    logic [BITS-1:0]      read_data_s;
    logic [BITS-1:0]      halt_value_r;
    logic                 ram_we_s;
    logic                 hs_s;
    logic                 full_s;
    logic                 halt_hit_s;
    logic                 in_ready_s;
    logic                 drive_s;
    logic                 cpu_reset_r;
    logic                 halted_r;
    logic                 load_err_r;

    assign cpu_idx_s  = bus.cpu_address[ADDR_BITS-1:0];
    assign hs_s       = bus.in_valid && in_ready_s;
    assign full_s     = (ptr_r == LAST_IDX);
    assign halt_hit_s = (state_r == RUN) && bus.cpu_write && (cpu_idx_s == HALT_IDX);

    generate
        if (BITS > ADDR_BITS) begin : g_alias
            logic unused_addr_s;
            assign unused_addr_s = ^bus.cpu_address[BITS-1:ADDR_BITS];
        end
    endgenerate

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: a HALT handshake behaves like the first word of a fresh load.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LOAD, HALT: begin
                if (hs_s) begin
                    if (bus.in_last || full_s) begin
                        state_next_s = RUN;
                    end else begin
                        state_next_s = LOAD;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            RUN: begin
                if (halt_hit_s) begin
                    state_next_s = HALT;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = LOAD;
        endcase
    end

    // Output decode: RAM port ownership (loader vs. core) and bus drive enable.
    always_comb begin
        in_ready_s  = 1'b0;
        drive_s     = 1'b0;
        ram_we_s    = 1'b0;
        ram_addr_s  = ptr_r;
        ram_wdata_s = bus.in_data;
        case (state_r)
            LOAD, HALT: begin
                in_ready_s  = 1'b1;
                ram_we_s    = hs_s;
                ram_addr_s  = ptr_r;
                ram_wdata_s = bus.in_data;
            end
            RUN: begin
                drive_s     = !bus.cpu_write;
                ram_we_s    = bus.cpu_write && (cpu_idx_s != HALT_IDX);
                ram_addr_s  = cpu_idx_s;
                ram_wdata_s = cpu_data;
            end
            default: begin
                in_ready_s = 1'b0;
                ram_we_s   = 1'b0;
            end
        endcase
    end

    // Registered outputs and load pointer; ptr returns to 0 whenever RUN is entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_r        <= {ADDR_BITS{1'b0}};
            cpu_reset_r  <= 1'b1;
            halted_r     <= 1'b0;
            halt_value_r <= {BITS{1'b0}};
            load_err_r   <= 1'b0;
        end else begin
            cpu_reset_r <= (state_r != RUN) || (state_next_s != RUN);
            if (hs_s) begin
                ptr_r <= (state_next_s == RUN) ? {ADDR_BITS{1'b0}} : ptr_r + PTR_ONE;
            end else begin
                ptr_r <= ptr_r;
            end
            if (halt_hit_s) begin
                halted_r     <= 1'b1;
                halt_value_r <= cpu_data;
            end else if (hs_s && (state_r == HALT)) begin
                halted_r     <= 1'b0;
                halt_value_r <= halt_value_r;
            end else begin
                halted_r     <= halted_r;
                halt_value_r <= halt_value_r;
            end
            if (hs_s && (state_r == LOAD) && !bus.in_last && full_s) begin
                load_err_r <= 1'b1;
            end else if (hs_s && (state_r == HALT)) begin
                load_err_r <= 1'b0;
            end else begin
                load_err_r <= load_err_r;
            end
        end
    end

    subleq_loader_mem_ram #(
        .BITS      (BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clock (clock),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // The halt mailbox always reads as zero.
    assign read_data_s = (cpu_idx_s == HALT_IDX) ? {BITS{1'b0}} : ram_rdata_s;
    assign cpu_data    = drive_s ? read_data_s : {BITS{1'bz}};

    assign bus.in_ready   = in_ready_s;
    assign bus.cpu_reset  = cpu_reset_r;
    assign bus.halted     = halted_r;
    assign bus.halt_value = halt_value_r;
    assign bus.load_err   = load_err_r;

endmodule

// File: tb/tb_subleq_loader_mem.sv
// Randomised bench for subleq_loader_mem: the bench plays both the program source
// and the core, and predicts every output from a memory-image reference model.
module tb_subleq_loader_mem;

    localparam int BITS   = 8;
    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic            clock;
    logic            reset;
    logic [BITS-1:0] core_wdata;
    logic            core_drive;
    wire  [BITS-1:0] cpu_data;

    int n_cmp;
    int n_bad;

    logic [7:0] m_mem [32];
    int         m_state;
    int         m_ptr;
    int         run_age;
    logic       m_halted;
    logic       m_err;
    logic [7:0] m_hv;

    subleq_loader_mem_if #(.BITS(BITS)) bus ();

    subleq_loader_mem #(
        .BITS      (8),
        .ADDR_BITS (5),
        .HALT_ADDR (31)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus.slave),
        .cpu_data (cpu_data)
    );

    assign cpu_data = core_drive ? core_wdata : 8'bzzzzzzzz;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.in_data     = 8'h00;
        bus.in_last     = 1'b0;
        bus.cpu_write   = 1'b0;
        bus.cpu_address = 8'h00;
        core_wdata      = 8'h00;
        core_drive      = 1'b0;
    endtask

    task automatic check_regs();
        chk("cpu_reset",  32'(bus.cpu_reset),  32'(!(m_state == M_RUN && run_age >= 1)));
        chk("halted",     32'(bus.halted),     32'(m_halted));
        chk("halt_value", 32'(bus.halt_value), 32'(m_hv));
        chk("load_err",   32'(bus.load_err),   32'(m_err));
        chk("in_ready",   32'(bus.in_ready),   32'(m_state != M_RUN));
    endtask

    // One bus cycle: drive at negedge, check the read bus, then check the edge's effect.
    task automatic cycle(input bit v, input logic [7:0] d, input bit l,
                         input bit w, input logic [7:0] a, input logic [7:0] wd);
        logic [4:0] idx;
        logic [7:0] rexp;
        @(negedge clock);
        bus.in_valid    = v;
        bus.in_data     = d;
        bus.in_last     = l;
        bus.cpu_write   = w;
        bus.cpu_address = a;
        core_wdata      = wd;
        core_drive      = w;
        #1;
        idx = a[4:0];
        chk("in_ready_comb", 32'(bus.in_ready), 32'(m_state != M_RUN));
        if (m_state == M_RUN && !w) begin
            rexp = (idx == 5'd31) ? 8'h00 : m_mem[idx];
            chk("cpu_data", 32'(cpu_data), 32'(rexp));
        end
        @(posedge clock);
        #1;
        if (v && m_state != M_RUN) begin
            if (m_state == M_HALT) begin
                m_halted = 1'b0;
                m_err    = 1'b0;
                m_ptr    = 0;
            end
            m_mem[m_ptr] = d;
            if (l || m_ptr == 31) begin
                if (!l) m_err = 1'b1;
                m_state = M_RUN;
                run_age = 0;
                m_ptr   = 0;
            end else begin
                m_ptr++;
                m_state = M_LOAD;
            end
        end else if (m_state == M_RUN) begin
            run_age++;
            if (w && idx == 5'd31) begin
                m_halted = 1'b1;
                m_hv     = wd;
                m_state  = M_HALT;
            end else if (w) begin
                m_mem[idx] = wd;
            end
        end
        check_regs();
    endtask

    task automatic apply_reset();
        @(posedge clock);
        #3;
        idle_inputs();
        reset = 1'b1;
        #1;
        m_state  = M_LOAD;
        m_ptr    = 0;
        m_halted = 1'b0;
        m_err    = 1'b0;
        m_hv     = 8'h00;
        run_age  = 0;
        check_regs();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Push a word stream, with random idle gaps carrying ignored core writes.
    task automatic load(input logic [7:0] words[$], input bit with_last);
        for (int i = 0; i < words.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cycle(1'b0, 8'($urandom), 1'b0, 1'($urandom_range(0, 1)),
                      8'($urandom), 8'($urandom));
            end
            cycle(1'b1, words[i], with_last && (i == words.size() - 1), 1'b0, 8'h00, 8'h00);
        end
    endtask

    task automatic run_rand(input int n);
        logic [7:0] a;
        bit         w;
        for (int i = 0; i < n; i++) begin
            a = 8'($urandom_range(0, 255));
            w = ($urandom_range(0, 2) == 0);
            if (w && a[4:0] == 5'd31) a[0] = 1'b0;
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  w, a, 8'($urandom));
        end
    endtask

    initial begin
        logic [7:0] q[$];
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'hxx;

        apply_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'($urandom), 8'h00);

        // Full-depth load without in_last: forced into RUN with load_err.
        q = {};
        for (int i = 0; i < 32; i++) q.push_back(8'($urandom));
        load(q, 1'b0);
        run_rand(40);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'd31, 8'h00);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'd63, 8'h00);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'd42, 8'hA5);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'd10, 8'h00);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'd74, 8'h00);
        chk("ram10_model", 32'(m_mem[10]), 32'h0000_00A5);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'd95, 8'h3C);

        // Parked core: writes, including to the mailbox, are ignored.
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'd5, 8'h77);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'd31, 8'h11);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'h00);

        // One-word program from HALT goes straight to RUN.
        q = {8'h1F};
        load(q, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'h00);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'd5, 8'h00);
        run_rand(20);

        // Reset mid-run, then a partial load interrupted by reset.
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'd3, 8'h5A);
        apply_reset();
        q = {8'h11, 8'h22, 8'h33};
        load(q, 1'b0);
        apply_reset();

        // Directed program image, then the core reports 2 through the mailbox.
        q = {};
        for (int i = 0; i < 22; i++) q.push_back(8'h00);
        q[0] = 8'd20; q[8] = 8'd21; q[16] = 8'd31; q[20] = 8'd3; q[21] = 8'd5;
        load(q, 1'b1);
        for (int i = 0; i < 24; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'(i), 8'h00);
        run_rand(10);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'd31, 8'd2);
        chk("halt_value_two", 32'(bus.halt_value), 32'd2);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'h00);
        apply_reset();

        // Random-length program with in_last, then a final random run.
        q = {};
        for (int i = 0; i < int'($urandom_range(2, 31)); i++) q.push_back(8'($urandom));
        load(q, 1'b1);
        run_rand(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
